// File: rtl/riscv_lsu.sv
// Load/store unit: forwards ALU results to write-back after one cycle and runs one data-memory
// transaction at a time, holding the execute stage in stall until the memory acknowledges.
module riscv_lsu #(
  parameter int XLEN = 32,
  parameter int REGN = 32,
  parameter int REGA = $clog2(REGN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [REGA-1:0]   ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [REGA-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exception,
  output logic [XLEN-1:0]   exception_addr
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [REGA-1:0]   r_rd;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN/8-1:0] r_wstrb;

  logic              r_wb_valid;
  logic [REGA-1:0]   r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_exc;
  logic [XLEN-1:0]   r_exc_addr;

  logic              w_is_mem;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_fault;
  logic              w_start;
  logic              w_done;
  logic [XLEN-1:0]   w_st_wdata;
  logic [XLEN/8-1:0] w_st_wstrb;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_ld_data;

  // Decode of the instruction presented by EX
  always_comb begin
    w_is_mem     = ex_load | ex_store;
    w_illegal    = (ex_load && ex_store) ||
                   (ex_load && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111)) ||
                   (ex_store && (ex_funct3[2] || ex_funct3 == 3'b011));
    w_misaligned = (ex_funct3[1:0] == 2'b01 && ex_result[0]) ||
                   (ex_funct3[1:0] == 2'b10 && ex_result[1:0] != 2'b00);
    w_accept     = (r_state == S_IDLE) && ex_valid;
    w_fault      = w_accept && w_is_mem && (w_illegal || w_misaligned);
    w_start      = w_accept && w_is_mem && !w_illegal && !w_misaligned;
    w_done       = (r_state == S_BUSY) && mem_ack;
  end

  // Store lane replication and strobes; loads never write
  always_comb begin
    w_st_wdata = ex_store_data;
    w_st_wstrb = '0;
    case (ex_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{ex_store_data[7:0]}};
        w_st_wstrb = 4'b0001 << ex_result[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{ex_store_data[15:0]}};
        w_st_wstrb = ex_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = ex_store_data;
        w_st_wstrb = 4'b1111;
      end
    endcase
    if (!ex_store) begin
      w_st_wstrb = '0;
    end
  end

  // Load lane select and extension
  always_comb begin
    w_lane    = mem_rdata >> {r_addr[1:0], 3'b000};
    w_ld_data = w_lane;
    case (r_size)
      2'b00:   w_ld_data = r_unsigned ? {{(XLEN-8){1'b0}}, w_lane[7:0]}
                                      : {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_ld_data = r_unsigned ? {{(XLEN-16){1'b0}}, w_lane[15:0]}
                                      : {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      default: w_ld_data = w_lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request follows state directly so an async reset withdraws it at once
  always_comb begin
    stall   = (r_state == S_BUSY);
    mem_req = (r_state == S_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else if (w_start) begin
      r_addr     <= ex_result;
      r_size     <= ex_funct3[1:0];
      r_unsigned <= ex_funct3[2];
      r_rd       <= ex_rd;
      r_we       <= ex_store;
      r_wdata    <= w_st_wdata;
      r_wstrb    <= w_st_wstrb;
    end
  end

  // Write-back and exception outputs are single-cycle pulses, zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
      if (w_accept && !w_is_mem) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= ex_rd;
        r_wb_data  <= ex_result;
      end
      if (w_fault) begin
        r_exc      <= 1'b1;
        r_exc_addr <= ex_result;
      end
      if (w_done && !r_we) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_ld_data;
      end
    end
  end

  assign mem_we         = r_we;
  assign mem_addr       = {r_addr[XLEN-1:2], 2'b00};
  assign mem_wdata      = r_wdata;
  assign mem_wstrb      = r_wstrb;
  assign wb_valid       = r_wb_valid;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign exception      = r_exc;
  assign exception_addr = r_exc_addr;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: scoreboard of expected write-back/exception events plus direct memory-port checks.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exception;
  logic [31:0] exception_addr;

  riscv_lsu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exception(exception), .exception_addr(exception_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          exc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && (wb_valid || exception)) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind", 32'(exception), 32'(e.exc));
        chk("event_wb_excl", 32'(wb_valid & exception), 32'd0);
        if (e.exc) begin
          chk("exc_addr", exception_addr, e.data);
        end else begin
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic push(input bit exc, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.exc = exc; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sdata);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_rd = rd; ex_result = res; ex_store_data = sdata;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    drive(1'b0, 1'b0, 3'b000, rd, res, 32'h0);
    push(1'b0, rd, res);
    chk("alu_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic fault(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr);
    drive(ld, st, f3, 5'd7, addr, 32'h0);
    push(1'b1, 5'd0, addr);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("fault_no_req", 32'(mem_req), 32'd0);
    chk("fault_no_stall", 32'(stall), 32'd0);
  endtask

  task automatic mem_op(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input int wait_cyc, input logic [3:0] x_strb, input logic [31:0] x_wdata,
                        input logic [31:0] x_load);
    drive(ld, st, f3, rd, addr, sdata);
    if (ld) push(1'b0, rd, x_load);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      chk("busy_req", 32'(mem_req), 32'd1);
      chk("busy_stall", 32'(stall), 32'd1);
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("mem_we", 32'(mem_we), 32'(st));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(x_strb));
      if (st) chk("mem_wdata", mem_wdata, x_wdata);
      @(posedge clk); #1;
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_exc", 32'(exception), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ALU passthrough, back to back
    alu(5'd1, 32'h11);
    alu(5'd2, 32'h22);
    alu(5'd3, 32'h33);
    chk("alu_tail_stall", 32'(stall), 32'd0);
    alu(5'd0, 32'hCAFE_0000);
    @(posedge clk); #1;

    // Loads: LB, LBU, LHU, LH, LW
    mem_op(1'b1, 1'b0, 3'b000, 5'd4, 32'h1003, 32'h0, 32'h80FF_FF7F, 3, 4'b0000, 32'h0, 32'hFFFF_FF80);
    mem_op(1'b1, 1'b0, 3'b100, 5'd5, 32'h1003, 32'h0, 32'h80FF_FF7F, 1, 4'b0000, 32'h0, 32'h0000_0080);
    mem_op(1'b1, 1'b0, 3'b101, 5'd6, 32'h2002, 32'h0, 32'hBEEF_1234, 2, 4'b0000, 32'h0, 32'h0000_BEEF);
    mem_op(1'b1, 1'b0, 3'b001, 5'd6, 32'h2002, 32'h0, 32'hBEEF_1234, 1, 4'b0000, 32'h0, 32'hFFFF_BEEF);
    mem_op(1'b1, 1'b0, 3'b010, 5'd9, 32'h7000, 32'h0, 32'h1234_5678, 1, 4'b0000, 32'h0, 32'h1234_5678);
    alu(5'd10, 32'hA);

    // Stores: SB, SH, SW (no write-back expected)
    mem_op(1'b0, 1'b1, 3'b000, 5'd1, 32'h3001, 32'h0000_00AB, 32'h0, 2, 4'b0010, 32'hABAB_ABAB, 32'h0);
    mem_op(1'b0, 1'b1, 3'b001, 5'd1, 32'h3002, 32'h0000_5678, 32'h0, 1, 4'b1100, 32'h5678_5678, 32'h0);
    mem_op(1'b0, 1'b1, 3'b010, 5'd1, 32'h3004, 32'hDEAD_BEEF, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 32'd0);

    // Misaligned and illegal accesses, each followed immediately by an ALU op
    fault(1'b1, 1'b0, 3'b010, 32'h4002);
    alu(5'd11, 32'h55);
    fault(1'b0, 1'b1, 3'b001, 32'h4001);
    fault(1'b1, 1'b1, 3'b000, 32'h4000);
    fault(1'b1, 1'b0, 3'b011, 32'h4000);
    fault(1'b0, 1'b1, 3'b100, 32'h4000);
    alu(5'd12, 32'h66);

    // Reset while a load is outstanding
    drive(1'b1, 1'b0, 3'b010, 5'd13, 32'h5000, 32'h0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stale_ack_wb", 32'(wb_valid), 32'd0);
    chk("stale_ack_req", 32'(mem_req), 32'd0);
    alu(5'd14, 32'h77);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the execute stage and the write-back stage of the RV32 hart. It consumes the EX result, rd and store data. For loads and stores it runs a request/acknowledge transaction on the data-memory port, aligns load data and sign/zero-extends it, and builds byte strobes for stores. It forwards ALU results to write-back with one register of latency and stalls upstream while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath width; only 32 is supported (lane logic is RV32).
REGN, 32, number of architectural registers.
REGA, $clog2(REGN), register index width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
ex_valid  input  1  EX presents a valid instruction
ex_rd  input  REGA  destination register
ex_result  input  XLEN  ALU result; effective address for load/store
ex_store_data  input  XLEN  rs2 value for stores
ex_load  input  1  instruction is a load
ex_store  input  1  instruction is a store
ex_funct3  input  3  load/store width and sign (RV32I encoding)
stall  output  1  upstream must hold ex_* stable
mem_req  output  1  data-memory request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  XLEN  word-aligned address {addr[31:2],2'b00}
mem_wdata  output  XLEN  lane-replicated store data
mem_wstrb  output  XLEN/8  byte write enables
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  XLEN  read data, valid when mem_ack=1
wb_valid  output  1  write-back entry valid (one-cycle pulse)
wb_rd  output  REGA  write-back destination
wb_data  output  XLEN  write-back value
exception  output  1  one-cycle pulse: misaligned or illegal access
exception_addr  output  XLEN  faulting effective address

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous, so a reset mid-transaction drops mem_req immediately and discards the access. An ack arriving after reset is ignored.
- States: IDLE and BUSY. stall = (state == BUSY), combinational.
- In IDLE, ex_valid is sampled every cycle. Non-memory instruction (ex_load=ex_store=0): the next cycle carries wb_valid=1, wb_rd=ex_rd, wb_data=ex_result. Latency is 1 and throughput is 1 per cycle.
- Legality checks:
  - ex_load and ex_store both 1: illegal.
  - Load funct3 values 011, 110 and 111: illegal.
  - Store with funct3[2]=1 or funct3=011: illegal.
  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00.
- On an illegal or misaligned access: the next cycle carries exception=1 and exception_addr=ex_result. wb_valid=0, no mem_req, state stays IDLE.
- On a legal load or store: register the address, width, sign, rd and store data, and go to BUSY. mem_req=1 starting the next cycle. mem_addr, mem_we, mem_wdata and mem_wstrb hold stable until the ack.
- Store strobes and data:
  - Byte: wstrb = 1<<addr[1:0], wdata = byte replicated x4.
  - Half: wstrb = 0011 (addr[1]=0) or 1100, wdata = half replicated x2.
  - Word: wstrb = 1111.
  - Loads drive wstrb = 0000.
- BUSY plus mem_ack: mem_req deasserts the next cycle and state returns to IDLE.
  - Load: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. The next cycle carries wb_valid=1 with wb_rd and wb_data.
  - Store: wb_valid stays 0.
- The first IDLE cycle after completion accepts a new ex instruction, so minimum memory-op occupancy is 2 cycles.
- mem_ack while IDLE is ignored.
- The ack may arrive any number of cycles after mem_req. mem_req stays asserted indefinitely and there is no timeout.
- rd=0 is forwarded unchanged with wb_valid=1; write-back discards writes to x0.
- Outputs wb_* and exception are registered pulses. They are 0 in any cycle without a completing event.

Test Plan:
- ALU passthrough: three back-to-back ex_valid with ex_result 0x11, 0x22, 0x33 and rd 1..3 -> wb_valid on three consecutive cycles with matching data and rd, stall=0 throughout.
- LB sign-extend: addr 0x1003, mem_rdata 0x80FF_FF7F, ack after 3 cycles -> mem_addr 0x1000 held 3 cycles, wb_data 0xFFFF_FF80, stall high until ack.
- LHU: addr 0x2002, mem_rdata 0xBEEF_1234 -> wb_data 0x0000_BEEF. The same read as LH -> 0xFFFF_BEEF.
- SB/SH/SW: SB at 0x3001 with data 0xAB -> wstrb 0010, wdata 0xABAB_ABAB. SH at 0x3002 -> wstrb 1100. SW -> wstrb 1111. No wb_valid for any of them.
- Misaligned: LW at 0x4002 -> exception=1 with exception_addr=0x4002, mem_req never asserted, wb_valid=0. The next instruction is accepted the following cycle.
- Reset mid-transaction: assert rst while BUSY with mem_req=1 -> mem_req=0 immediately. A stale mem_ack after reset produces no wb_valid.
